// File: rtl/branch_pkg.sv
// Shared constants for the execute-stage branch resolver:
// condition codes, op kinds and the default datapath width.
package branch_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    OPK_BRANCH = 2'b00,
    OPK_JAL    = 2'b01,
    OPK_JALR   = 2'b10,
    OPK_RSVD   = 2'b11
  } opk_e;

endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// Operand comparator: equality plus signed and unsigned less-than.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            eq,
  output logic            ltSigned,
  output logic            ltUnsigned
);

  assign eq         = (rs1 == rs2);
  assign ltUnsigned = (rs1 < rs2);
  assign ltSigned   = ($signed(rs1) < $signed(rs2));

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves BRANCH/JAL/JALR in execute: direction, target, link,
// misprediction, behind one registered valid/ready output stage.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int IALIGN = 32,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [2:0]       funct3,
  input  logic [1:0]       op_kind,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [XLEN-1:0]  target,
  output logic [XLEN-1:0]  link,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             mispredict,
  output logic             illegal,
  output logic             misalign,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic            eq;
  logic            ltSigned;
  logic            ltUnsigned;
  logic            takenC;
  logic            illegalC;
  logic            misalignC;
  logic            mispredC;
  logic [XLEN-1:0] tgtC;
  logic [XLEN-1:0] linkC;
  logic            accept;
  logic            retire;

  branch_cmp #(.XLEN(XLEN)) uCmp (
    .rs1        (rs1),
    .rs2        (rs2),
    .eq         (eq),
    .ltSigned   (ltSigned),
    .ltUnsigned (ltUnsigned)
  );

  always_comb begin
    takenC   = 1'b0;
    illegalC = 1'b0;
    tgtC     = pc + imm;
    unique case (opk_e'(op_kind))
      OPK_BRANCH: begin
        unique case (funct3)
          F3_BEQ:  takenC = eq;
          F3_BNE:  takenC = !eq;
          F3_BLT:  takenC = ltSigned;
          F3_BGE:  takenC = !ltSigned;
          F3_BLTU: takenC = ltUnsigned;
          F3_BGEU: takenC = !ltUnsigned;
          default: illegalC = 1'b1;
        endcase
      end
      OPK_JAL:  takenC = 1'b1;
      OPK_JALR: begin
        takenC = 1'b1;
        tgtC   = (rs1 + imm) & ~XLEN'(1);
      end
      default:  illegalC = 1'b1;
    endcase
  end

  assign linkC = pc + XLEN'(4);

  // Compressed-capable cores only need halfword alignment
  assign misalignC = takenC &&
                     ((IALIGN == 16) ? tgtC[0] : (tgtC[1:0] != 2'b00));

  assign mispredC = !illegalC && !misalignC &&
                    ((takenC != pred_taken) ||
                     (takenC && (pred_target != tgtC)));

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign retire   = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      taken       <= 1'b0;
      target      <= '0;
      link        <= '0;
      redirect_pc <= '0;
      mispredict  <= 1'b0;
      illegal     <= 1'b0;
      misalign    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      taken       <= takenC;
      target      <= tgtC;
      link        <= linkC;
      redirect_pc <= takenC ? tgtC : linkC;
      mispredict  <= mispredC;
      illegal     <= illegalC;
      misalign    <= misalignC;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (retire) begin
      if (!illegal && (branch_cnt != '1))
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (mispredict && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed ops, spec-level model
// compared every cycle, plus literal checks on key results.
module tb_branch_resolve_unit;

  localparam int XL = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [XL-1:0] rs1, rs2, pc, imm, pred_target;
  logic [2:0]    funct3;
  logic [1:0]    op_kind;
  logic          pred_taken;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic          taken;
  logic [XL-1:0] target, link, redirect_pc;
  logic          mispredict, illegal, misalign;
  logic [CW-1:0] branch_cnt, mispred_cnt;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(.XLEN(XL), .IALIGN(32), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rs1         (rs1),
    .rs2         (rs2),
    .pc          (pc),
    .imm         (imm),
    .funct3      (funct3),
    .op_kind     (op_kind),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .taken       (taken),
    .target      (target),
    .link        (link),
    .redirect_pc (redirect_pc),
    .mispredict  (mispredict),
    .illegal     (illegal),
    .misalign    (misalign),
    .branch_cnt  (branch_cnt),
    .mispred_cnt (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          t;
    bit          il;
    bit          ma;
    bit          mp;
    logic [31:0] tgt;
    logic [31:0] lnk;
    logic [31:0] rpc;
  } res_t;

  bit   mValid;
  res_t mRes;
  int   mBc;
  int   mMc;

  function automatic res_t evalOp();
    res_t r;
    longint s1, s2;
    r.il  = (op_kind == 2'd3) ||
            (op_kind == 2'd0 && (funct3 == 3'd2 || funct3 == 3'd3));
    r.t   = 1'b0;
    r.tgt = pc + imm;
    s1 = longint'($signed(rs1));
    s2 = longint'($signed(rs2));
    if (op_kind == 2'd0 && !r.il) begin
      case (funct3)
        3'd0: r.t = (rs1 == rs2);
        3'd1: r.t = (rs1 != rs2);
        3'd4: r.t = (s1 < s2);
        3'd5: r.t = (s1 >= s2);
        3'd6: r.t = (rs1 < rs2);
        default: r.t = (rs1 >= rs2);
      endcase
    end else if (op_kind == 2'd1) begin
      r.t = 1'b1;
    end else if (op_kind == 2'd2) begin
      r.t   = 1'b1;
      r.tgt = ((rs1 + imm) / 2) * 2;
    end
    r.lnk = pc + 32'd4;
    r.rpc = r.t ? r.tgt : r.lnk;
    r.ma  = r.t && (r.tgt % 4 != 0);
    r.mp  = !r.il && !r.ma &&
            (r.t != pred_taken || (r.t && pred_target != r.tgt));
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mValid = 0;
      mBc    = 0;
      mMc    = 0;
    end else begin
      bit rdy;
      rdy = !mValid || out_ready;
      if (mValid && out_ready && !flush) begin
        if (!mRes.il) mBc = (mBc < 15) ? mBc + 1 : 15;
        if (mRes.mp)  mMc = (mMc < 15) ? mMc + 1 : 15;
      end
      if (flush)                     mValid = 0;
      else if (in_valid && rdy)      begin mValid = 1; mRes = evalOp(); end
      else if (out_ready)            mValid = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(mValid));
      chk("in_ready", 32'(in_ready), 32'(!mValid || out_ready));
      chk("branch_cnt", 32'(branch_cnt), 32'(mBc));
      chk("mispred_cnt", 32'(mispred_cnt), 32'(mMc));
      if (mValid) begin
        chk("taken", 32'(taken), 32'(mRes.t));
        chk("illegal", 32'(illegal), 32'(mRes.il));
        chk("misalign", 32'(misalign), 32'(mRes.ma));
        chk("mispredict", 32'(mispredict), 32'(mRes.mp));
        chk("link", link, mRes.lnk);
        chk("redirect_pc", redirect_pc, mRes.rpc);
        if (!mRes.il) chk("target", target, mRes.tgt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setOp(input logic [1:0] k, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] i,
                       input logic pt, input logic [31:0] ptg);
    op_kind = k; funct3 = f; rs1 = a; rs2 = b; pc = p; imm = i;
    pred_taken = pt; pred_target = ptg; in_valid = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; flush = 0; out_ready = 1;
    rs1 = 0; rs2 = 0; pc = 0; imm = 0; funct3 = 0; op_kind = 0;
    pred_taken = 0; pred_target = 0;
    #12;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst target", target, 0);
    chk("rst branch_cnt", 32'(branch_cnt), 0);
    rst_n = 1'b1;
    step();

    // signed LT: 1 < negative is false
    setOp(2'd0, 3'd4, 32'h1, 32'h80000001, 32'h100, 32'h20, 0, 0);
    step(); in_valid = 0;
    chk("blt taken", 32'(taken), 0);
    chk("blt redirect", redirect_pc, 32'h104);
    chk("blt mispredict", 32'(mispredict), 0);
    step();

    // unsigned LT of the same operands is true
    setOp(2'd0, 3'd6, 32'h1, 32'h80000001, 32'h100, 32'h20, 0, 0);
    step(); in_valid = 0;
    chk("bltu taken", 32'(taken), 1);
    chk("bltu target", target, 32'h120);
    chk("bltu mispredict", 32'(mispredict), 1);
    chk("bltu cnt before", 32'(mispred_cnt), 0);
    step();
    chk("bltu cnt after", 32'(mispred_cnt), 1);

    setOp(2'd2, 3'd0, 32'h1003, 0, 32'h400, 0, 0, 0);
    step(); in_valid = 0;
    chk("jalr target", target, 32'h1002);
    chk("jalr misalign", 32'(misalign), 1);
    chk("jalr mispredict", 32'(mispredict), 0);
    step();

    // backpressure: A held, B waits
    out_ready = 0;
    setOp(2'd1, 3'd3, 0, 0, 32'h200, 32'h40, 1, 32'h240);
    step();
    setOp(2'd0, 3'd0, 32'h5, 32'h5, 32'h300, 32'hFFFFFFF8, 0, 0);
    for (int n = 0; n < 3; n++) begin
      chk("hold in_ready", 32'(in_ready), 0);
      chk("hold target", target, 32'h240);
      step();
    end
    out_ready = 1;
    step(); in_valid = 0;
    chk("B target", target, 32'h2F8);
    chk("B cnt", 32'(branch_cnt), 4);
    step();
    chk("after B cnt", 32'(branch_cnt), 5);

    // flush on the same cycle as a retire and a new op
    out_ready = 0;
    setOp(2'd1, 3'd0, 0, 0, 32'h500, 32'h8, 0, 0);
    step();
    setOp(2'd1, 3'd0, 0, 0, 32'h600, 32'h8, 0, 0);
    flush = 1; out_ready = 1;
    step(); flush = 0; in_valid = 0;
    chk("flush out_valid", 32'(out_valid), 0);
    chk("flush branch_cnt", 32'(branch_cnt), 5);
    chk("flush mispred_cnt", 32'(mispred_cnt), 2);
    step();

    setOp(2'd0, 3'd2, 1, 1, 32'h700, 32'h10, 0, 0);
    step();
    setOp(2'd3, 3'd0, 1, 1, 32'h700, 32'h10, 0, 0);
    step(); in_valid = 0;
    chk("rsvd illegal", 32'(illegal), 1);
    step();
    chk("illegal no count", 32'(branch_cnt), 5);

    for (int f = 0; f < 8; f++) begin
      setOp(2'd0, 3'(f), 32'hFFFFFFFF, 32'h1, 32'h800, 32'h4, 1, 32'h804);
      step();
    end
    in_valid = 0;
    step();

    for (int n = 0; n < 20; n++) begin
      setOp(2'd1, 3'd0, 0, 0, 32'(n * 16), 32'h40, 0, 0);
      step();
    end
    in_valid = 0;
    step();
    chk("sat branch_cnt", 32'(branch_cnt), 32'hF);
    chk("sat mispred_cnt", 32'(mispred_cnt), 32'hF);

    setOp(2'd1, 3'd0, 0, 0, 32'h900, 32'h4, 1, 32'h904);
    step(); in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", 32'(out_valid), 0);
    chk("mid rst taken", 32'(taken), 0);
    chk("mid rst target", target, 0);
    chk("mid rst link", link, 0);
    chk("mid rst branch_cnt", 32'(branch_cnt), 0);
    chk("mid rst mispred_cnt", 32'(mispred_cnt), 0);
    #3 rst_n = 1'b1;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
